// File: rtl/monitor_drop_ctrl.sv
// Turns the security monitor's drop_packet flag into per-packet verdicts and a core recovery sequence.
// Optional build macro MONITOR_WATCHDOG_EN adds an ACTIVE-state timeout that is handled as a violation.
module monitor_drop_ctrl #(
  parameter int unsigned DRAIN_CYCLES    = 4,
  parameter int unsigned RECOVER_CYCLES  = 16,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned WATCHDOG_CYCLES = 4096
) (
  input  logic                 core_sp_clk,
  input  logic                 reset,
  input  logic                 drop_packet,
  input  logic                 pkt_start,
  input  logic                 pkt_done,
  output logic                 verdict_valid,
  output logic                 verdict_drop,
  input  logic                 verdict_ack,
  output logic                 core_reset,
  output logic                 monitor_flush,
  output logic [CNT_WIDTH-1:0] violation_count,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACTIVE  = 3'd1,
    S_DRAIN   = 3'd2,
    S_VERDICT = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  // Counters are loaded with N-1 so that the state lasts exactly N cycles.
  localparam logic [7:0]           DRAIN_LOAD   = 8'(DRAIN_CYCLES - 1);
  localparam logic [15:0]          RECOVER_LOAD = 16'(RECOVER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX      = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1'b1);

  state_t      state_r, state_nxt;
  logic [7:0]  drain_cnt_r, drain_cnt_nxt;
  logic [15:0] rec_cnt_r, rec_cnt_nxt;
  logic        drop_nxt;
  logic        flush_nxt;
  logic        viol_s;
  logic        wd_expire_s;

`ifdef MONITOR_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt_r;

  // Watchdog: counts cycles spent in ACTIVE, cleared in every other state.
  always_ff @(posedge core_sp_clk) begin
    if (reset) begin
      wd_cnt_r <= '0;
    end else if (state_r == S_ACTIVE) begin
      wd_cnt_r <= wd_cnt_r + WD_W'(1'b1);
    end else begin
      wd_cnt_r <= '0;
    end
  end

  assign wd_expire_s = (state_r == S_ACTIVE) && (wd_cnt_r == WD_LAST);
`else
  assign wd_expire_s = 1'b0;
`endif

  // Next-state logic; verdict_drop is held by default while waiting for ack.
  always_comb begin
    state_nxt     = state_r;
    drain_cnt_nxt = drain_cnt_r;
    rec_cnt_nxt   = rec_cnt_r;
    drop_nxt      = verdict_drop;
    flush_nxt     = 1'b0;
    viol_s        = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (pkt_start) begin
          state_nxt = S_ACTIVE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (drop_packet || wd_expire_s) begin
          viol_s    = 1'b1;
          drop_nxt  = 1'b1;
          state_nxt = S_VERDICT;
        end else if (pkt_done) begin
          drain_cnt_nxt = DRAIN_LOAD;
          state_nxt     = S_DRAIN;
        end else begin
          state_nxt = S_ACTIVE;
        end
      end
      S_DRAIN: begin
        if (drop_packet) begin
          viol_s    = 1'b1;
          drop_nxt  = 1'b1;
          state_nxt = S_VERDICT;
        end else if (drain_cnt_r == 8'd0) begin
          drop_nxt  = 1'b0;
          state_nxt = S_VERDICT;
        end else begin
          drain_cnt_nxt = drain_cnt_r - 8'd1;
        end
      end
      S_VERDICT: begin
        if (verdict_ack && verdict_drop) begin
          rec_cnt_nxt = RECOVER_LOAD;
          flush_nxt   = 1'b1;
          state_nxt   = S_RECOVER;
        end else if (verdict_ack) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_VERDICT;
        end
      end
      S_RECOVER: begin
        if (rec_cnt_r == 16'd0) begin
          state_nxt = S_IDLE;
        end else begin
          rec_cnt_nxt = rec_cnt_r - 16'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge core_sp_clk) begin
    if (reset) begin
      state_r         <= S_IDLE;
      drain_cnt_r     <= 8'd0;
      rec_cnt_r       <= 16'd0;
      verdict_valid   <= 1'b0;
      verdict_drop    <= 1'b0;
      core_reset      <= 1'b0;
      monitor_flush   <= 1'b0;
      busy            <= 1'b0;
      violation_count <= '0;
    end else begin
      state_r       <= state_nxt;
      drain_cnt_r   <= drain_cnt_nxt;
      rec_cnt_r     <= rec_cnt_nxt;
      verdict_valid <= (state_nxt == S_VERDICT);
      verdict_drop  <= (state_nxt == S_VERDICT) && drop_nxt;
      core_reset    <= (state_nxt == S_RECOVER);
      monitor_flush <= flush_nxt;
      busy          <= (state_nxt != S_IDLE);
      if (viol_s && (violation_count != CNT_MAX)) begin
        violation_count <= violation_count + CNT_ONE;
      end else begin
        violation_count <= violation_count;
      end
    end
  end

endmodule

// File: tb/tb_monitor_drop_ctrl.sv
// Directed self-checking bench for monitor_drop_ctrl; a second instance with a 2-bit counter checks saturation.
module tb_monitor_drop_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        drop_packet = 1'b0;
  logic        pkt_start = 1'b0;
  logic        pkt_done = 1'b0;
  logic        verdict_ack = 1'b0;
  logic        verdict_valid, verdict_drop, core_reset, monitor_flush, busy;
  logic [15:0] violation_count;
  logic        verdict_valid2, verdict_drop2, core_reset2, monitor_flush2, busy2;
  logic [1:0]  violation_count2;

  int vectors = 0;
  int miscompares = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  monitor_drop_ctrl #(
    .DRAIN_CYCLES(4), .RECOVER_CYCLES(16), .CNT_WIDTH(16), .WATCHDOG_CYCLES(100)
  ) dut (
    .core_sp_clk(clk), .reset(reset), .drop_packet(drop_packet), .pkt_start(pkt_start),
    .pkt_done(pkt_done), .verdict_valid(verdict_valid), .verdict_drop(verdict_drop),
    .verdict_ack(verdict_ack), .core_reset(core_reset), .monitor_flush(monitor_flush),
    .violation_count(violation_count), .busy(busy)
  );

  monitor_drop_ctrl #(
    .DRAIN_CYCLES(4), .RECOVER_CYCLES(16), .CNT_WIDTH(2), .WATCHDOG_CYCLES(100)
  ) dut2 (
    .core_sp_clk(clk), .reset(reset), .drop_packet(drop_packet), .pkt_start(pkt_start),
    .pkt_done(pkt_done), .verdict_valid(verdict_valid2), .verdict_drop(verdict_drop2),
    .verdict_ack(verdict_ack), .core_reset(core_reset2), .monitor_flush(monitor_flush2),
    .violation_count(violation_count2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    exp_cnt = 0;
    vectors++; if ({verdict_valid, verdict_drop, core_reset, monitor_flush, busy} !== 5'b0) begin miscompares++; $display("FAIL reset_outputs got=%b exp=00000", {verdict_valid, verdict_drop, core_reset, monitor_flush, busy}); end
    vectors++; if (violation_count !== 16'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", violation_count); end
  endtask

  task automatic test_clean();
    pkt_start = 1'b1; tick(); pkt_start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL clean_busy got=%b exp=1", busy); end
    repeat (9) tick();
    pkt_done = 1'b1; tick(); pkt_done = 1'b0;
    for (int c = 11; c < 15; c++) begin
      vectors++; if (verdict_valid !== 1'b0) begin miscompares++; $display("FAIL clean_drain_c%0d got=%b exp=0", c, verdict_valid); end
      tick();
    end
    vectors++; if ({verdict_valid, verdict_drop} !== 2'b10) begin miscompares++; $display("FAIL clean_verdict got=%b exp=10", {verdict_valid, verdict_drop}); end
    verdict_ack = 1'b1; tick(); verdict_ack = 1'b0;
    vectors++; if ({verdict_valid, busy, core_reset} !== 3'b000) begin miscompares++; $display("FAIL clean_after_ack got=%b exp=000", {verdict_valid, busy, core_reset}); end
    vectors++; if (violation_count !== 16'(exp_cnt)) begin miscompares++; $display("FAIL clean_count got=%0d exp=%0d", violation_count, exp_cnt); end
  endtask

  task automatic test_violation();
    pkt_start = 1'b1; tick(); pkt_start = 1'b0;
    repeat (4) tick();
    drop_packet = 1'b1; tick(); drop_packet = 1'b0;
    exp_cnt++;
    vectors++; if ({verdict_valid, verdict_drop} !== 2'b11) begin miscompares++; $display("FAIL viol_verdict got=%b exp=11", {verdict_valid, verdict_drop}); end
    vectors++; if (violation_count !== 16'(exp_cnt)) begin miscompares++; $display("FAIL viol_count got=%0d exp=%0d", violation_count, exp_cnt); end
    repeat (2) tick();
    vectors++; if ({verdict_valid, verdict_drop, core_reset} !== 3'b110) begin miscompares++; $display("FAIL viol_hold got=%b exp=110", {verdict_valid, verdict_drop, core_reset}); end
    verdict_ack = 1'b1; tick(); verdict_ack = 1'b0;
    vectors++; if ({verdict_valid, monitor_flush, core_reset} !== 3'b011) begin miscompares++; $display("FAIL viol_recover_c9 got=%b exp=011", {verdict_valid, monitor_flush, core_reset}); end
    tick();
    vectors++; if ({monitor_flush, core_reset} !== 2'b01) begin miscompares++; $display("FAIL viol_recover_c10 got=%b exp=01", {monitor_flush, core_reset}); end
    repeat (14) tick();
    vectors++; if ({core_reset, busy} !== 2'b11) begin miscompares++; $display("FAIL viol_recover_c24 got=%b exp=11", {core_reset, busy}); end
    tick();
    vectors++; if ({core_reset, busy} !== 2'b00) begin miscompares++; $display("FAIL viol_recover_c25 got=%b exp=00", {core_reset, busy}); end
  endtask

  task automatic test_late();
    bit ok;
    pkt_start = 1'b1; tick(); pkt_start = 1'b0;
    repeat (9) tick();
    pkt_done = 1'b1; tick(); pkt_done = 1'b0;
    tick();
    vectors++; if (verdict_valid !== 1'b0) begin miscompares++; $display("FAIL late_c12 got=%b exp=0", verdict_valid); end
    drop_packet = 1'b1; tick(); drop_packet = 1'b0;
    exp_cnt++;
    vectors++; if ({verdict_valid, verdict_drop} !== 2'b11) begin miscompares++; $display("FAIL late_verdict got=%b exp=11", {verdict_valid, verdict_drop}); end
    vectors++; if (violation_count !== 16'(exp_cnt)) begin miscompares++; $display("FAIL late_count got=%0d exp=%0d", violation_count, exp_cnt); end
    verdict_ack = 1'b1; tick(); verdict_ack = 1'b0;
    wait_idle(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL late_idle_timeout got=%b exp=1", ok); end
  endtask

  task automatic test_same_cycle();
    bit ok;
    pkt_start = 1'b1; tick(); pkt_start = 1'b0;
    repeat (3) tick();
    pkt_done = 1'b1; drop_packet = 1'b1; tick(); pkt_done = 1'b0; drop_packet = 1'b0;
    exp_cnt++;
    vectors++; if ({verdict_valid, verdict_drop} !== 2'b11) begin miscompares++; $display("FAIL same_verdict got=%b exp=11", {verdict_valid, verdict_drop}); end
    vectors++; if (violation_count !== 16'(exp_cnt)) begin miscompares++; $display("FAIL same_count got=%0d exp=%0d", violation_count, exp_cnt); end
    verdict_ack = 1'b1; tick(); verdict_ack = 1'b0;
    wait_idle(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL same_idle_timeout got=%b exp=1", ok); end
  endtask

  task automatic test_ignored();
    bit ok;
    drop_packet = 1'b1; pkt_done = 1'b1; repeat (3) tick(); drop_packet = 1'b0; pkt_done = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ign_idle_busy got=%b exp=0", busy); end
    vectors++; if (violation_count !== 16'(exp_cnt)) begin miscompares++; $display("FAIL ign_idle_count got=%0d exp=%0d", violation_count, exp_cnt); end
    pkt_start = 1'b1; tick(); pkt_start = 1'b0;
    drop_packet = 1'b1; tick(); drop_packet = 1'b0;
    exp_cnt++;
    pkt_start = 1'b1; repeat (3) tick(); pkt_start = 1'b0;
    vectors++; if ({verdict_valid, verdict_drop, busy} !== 3'b111) begin miscompares++; $display("FAIL ign_verdict_state got=%b exp=111", {verdict_valid, verdict_drop, busy}); end
    verdict_ack = 1'b1; tick(); verdict_ack = 1'b0;
    drop_packet = 1'b1; repeat (5) tick();
    vectors++; if (core_reset !== 1'b1) begin miscompares++; $display("FAIL ign_recover_state got=%b exp=1", core_reset); end
    wait_idle(ok);
    drop_packet = 1'b0;
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL ign_idle_timeout got=%b exp=1", ok); end
    vectors++; if (violation_count !== 16'(exp_cnt)) begin miscompares++; $display("FAIL ign_recover_count got=%0d exp=%0d", violation_count, exp_cnt); end
  endtask

  task automatic test_saturation();
    bit ok;
    int sat;
    reset = 1'b1; tick(); reset = 1'b0;
    exp_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      pkt_start = 1'b1; tick(); pkt_start = 1'b0;
      drop_packet = 1'b1; tick(); drop_packet = 1'b0;
      verdict_ack = 1'b1; tick(); verdict_ack = 1'b0;
      wait_idle(ok);
      exp_cnt++;
      sat = (k > 3) ? 3 : k;
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL sat_idle_timeout_%0d got=%b exp=1", k, ok); end
      vectors++; if (violation_count !== 16'(exp_cnt)) begin miscompares++; $display("FAIL sat_count16_%0d got=%0d exp=%0d", k, violation_count, exp_cnt); end
      vectors++; if (violation_count2 !== 2'(sat)) begin miscompares++; $display("FAIL sat_count2_%0d got=%0d exp=%0d", k, violation_count2, sat); end
    end
  endtask

  task automatic test_reset_midop();
    pkt_start = 1'b1; tick(); pkt_start = 1'b0;
    drop_packet = 1'b1; tick(); drop_packet = 1'b0;
    verdict_ack = 1'b1; tick(); verdict_ack = 1'b0;
    repeat (9) tick();
    vectors++; if (core_reset !== 1'b1) begin miscompares++; $display("FAIL rst_pre_core_reset got=%b exp=1", core_reset); end
    reset = 1'b1; tick(); reset = 1'b0;
    exp_cnt = 0;
    vectors++; if ({core_reset, busy, verdict_valid} !== 3'b000) begin miscompares++; $display("FAIL rst_recover_outputs got=%b exp=000", {core_reset, busy, verdict_valid}); end
    vectors++; if ({violation_count, violation_count2} !== 18'd0) begin miscompares++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", violation_count, violation_count2); end
    pkt_start = 1'b1; tick(); pkt_start = 1'b0;
    drop_packet = 1'b1; tick(); drop_packet = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++; if ({verdict_valid, verdict_drop, busy} !== 3'b000) begin miscompares++; $display("FAIL rst_verdict_outputs got=%b exp=000", {verdict_valid, verdict_drop, busy}); end
  endtask

  task automatic test_watchdog();
`ifdef MONITOR_WATCHDOG_EN
    bit ok;
    pkt_start = 1'b1; tick(); pkt_start = 1'b0;
    repeat (99) tick();
    vectors++; if (verdict_valid !== 1'b0) begin miscompares++; $display("FAIL wd_c100 got=%b exp=0", verdict_valid); end
    tick();
    exp_cnt++;
    vectors++; if ({verdict_valid, verdict_drop} !== 2'b11) begin miscompares++; $display("FAIL wd_verdict got=%b exp=11", {verdict_valid, verdict_drop}); end
    vectors++; if (violation_count !== 16'(exp_cnt)) begin miscompares++; $display("FAIL wd_count got=%0d exp=%0d", violation_count, exp_cnt); end
    verdict_ack = 1'b1; tick(); verdict_ack = 1'b0;
    wait_idle(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL wd_idle_timeout got=%b exp=1", ok); end
`else
    pkt_start = 1'b1; tick(); pkt_start = 1'b0;
    repeat (1000) tick();
    vectors++; if ({busy, verdict_valid} !== 2'b10) begin miscompares++; $display("FAIL nowd_active got=%b exp=10", {busy, verdict_valid}); end
    vectors++; if (violation_count !== 16'(exp_cnt)) begin miscompares++; $display("FAIL nowd_count got=%0d exp=%0d", violation_count, exp_cnt); end
    reset = 1'b1; tick(); reset = 1'b0;
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_clean();
    test_violation();
    test_late();
    test_same_cycle();
    test_ignored();
    test_saturation();
    test_reset_midop();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
